// File: rtl/conv3x3_stream.sv
// Streaming 3x3 signed convolution engine.
// Pixels arrive in raster order; two line buffers hold the previous two rows
// and a 3x3 window register shifts once per accepted pixel. Each completed
// window passes through a product register and then an adder-tree register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; config is latched when start is seen
// LOAD_FLT | accepting the nine coefficients k0..k8
// RUN      | accepting pixels and emitting window results
// DRAIN    | two cycles that let the last window leave the pipeline
// DONE     | one-cycle done pulse (cfg_err too if the config was illegal)
module conv3x3_stream #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 36,
  parameter int MAX_ROW = 256,
  parameter int ROW_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_W-1:0]         cfg_row_length,
  input  logic [ROW_W-1:0]         cfg_num_rows,
  input  logic                     cfg_stride,
  input  logic                     cfg_reuse_flt,
  input  logic                     flt_valid,
  input  logic signed [DATA_W-1:0] flt_data,
  output logic                     flt_ready,
  input  logic                     pix_valid,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     pix_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     done,
  output logic                     cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FLT, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_next;

  logic [ROW_W-1:0] w_len, h_len, col, row;
  logic             stride, err;
  logic [3:0]       flt_cnt;
  logic             drain_cnt;

  logic signed [DATA_W-1:0]   coef     [9];
  logic signed [DATA_W-1:0]   win      [9];
  logic signed [DATA_W-1:0]   win_next [9];
  logic signed [DATA_W-1:0]   lb0      [MAX_ROW];
  logic signed [DATA_W-1:0]   lb1      [MAX_ROW];
  logic signed [2*DATA_W-1:0] prod     [9];
  logic signed [2*DATA_W-1:0] prod_q   [9];
  logic                       v1;
  logic signed [ACC_W-1:0]    sum;

  logic cfg_bad, flt_wr, accept, emit, last_pix;

  // W > MAX_ROW is only reachable when ROW_W is wider than the buffer index
  assign cfg_bad = (cfg_row_length < ROW_W'(3)) || (cfg_num_rows < ROW_W'(3)) ||
                   (int'(cfg_row_length) > MAX_ROW);
  assign flt_wr   = flt_valid && flt_ready;
  assign accept   = pix_valid && pix_ready;
  assign emit     = (row >= ROW_W'(2)) && (col >= ROW_W'(2)) &&
                    (!stride || (!row[0] && !col[0]));
  assign last_pix = (row == h_len - ROW_W'(1)) && (col == w_len - ROW_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad)            state_next = S_DONE;
          else if (cfg_reuse_flt) state_next = S_RUN;
          else                    state_next = S_LOAD_FLT;
        end
      end
      S_LOAD_FLT: if (flt_wr && flt_cnt == 4'd8) state_next = S_RUN;
      S_RUN:      if (accept && last_pix) state_next = S_DRAIN;
      S_DRAIN:    if (drain_cnt == 1'b0) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    flt_ready = (state == S_LOAD_FLT);
    pix_ready = (state == S_RUN);
    done      = (state == S_DONE);
    cfg_err   = (state == S_DONE) && err;
  end

  // Config latch, counters, coefficients, window and the two pipeline stages
  always_ff @(posedge clk) begin
    if (rst) begin
      w_len     <= '0;
      h_len     <= '0;
      stride    <= 1'b0;
      err       <= 1'b0;
      flt_cnt   <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < 9; k++) begin
        coef[k]   <= '0;
        win[k]    <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      if (state == S_IDLE && start) begin
        w_len   <= cfg_row_length;
        h_len   <= cfg_num_rows;
        stride  <= cfg_stride;
        err     <= cfg_bad;
        flt_cnt <= '0;
        col     <= '0;
        row     <= '0;
      end
      if (flt_wr) begin
        coef[flt_cnt] <= flt_data;
        flt_cnt       <= flt_cnt + 4'd1;
      end
      if (accept) begin
        win <= win_next;
        if (col == w_len - ROW_W'(1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + ROW_W'(1);
        end
      end
      // DRAIN down-counter: loaded while running, terminal count at zero
      if (state == S_RUN)        drain_cnt <= 1'b1;
      else if (state == S_DRAIN) drain_cnt <= 1'b0;
      v1 <= accept && emit;
      if (accept && emit) prod_q <= prod;
      out_valid <= v1;
      if (v1) out_data <= sum;
    end
  end

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2 at the current column
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= pix_data;
      lb1[col] <= lb0[col];
    end
  end

  // Window as it will look after this pixel shifts in, and its nine products
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_next[3*i]   = win[3*i+1];
      win_next[3*i+1] = win[3*i+2];
    end
    win_next[2] = lb1[col];
    win_next[5] = lb0[col];
    win_next[8] = pix_data;
    for (int k = 0; k < 9; k++) begin
      prod[k] = $signed({{DATA_W{coef[k][DATA_W-1]}}, coef[k]}) *
                $signed({{DATA_W{win_next[k][DATA_W-1]}}, win_next[k]});
    end
  end

  // Adder tree over sign-extended products
  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) begin
      sum = sum + $signed({{(ACC_W-2*DATA_W){prod_q[k][2*DATA_W-1]}}, prod_q[k]});
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: a table of frames with hand-computed
// results, followed by reset-abort and illegal-config sequences.
module tb_conv3x3_stream;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 36;
  localparam int MAX_ROW = 256;
  localparam int ROW_W   = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [ROW_W-1:0]         cfg_row_length = '0;
  logic [ROW_W-1:0]         cfg_num_rows = '0;
  logic                     cfg_stride = 1'b0;
  logic                     cfg_reuse_flt = 1'b0;
  logic                     flt_valid = 1'b0;
  logic signed [DATA_W-1:0] flt_data = '0;
  logic                     flt_ready;
  logic                     pix_valid = 1'b0;
  logic signed [DATA_W-1:0] pix_data = '0;
  logic                     pix_ready;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     done;
  logic                     cfg_err;

  conv3x3_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_ROW(MAX_ROW), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_row_length(cfg_row_length), .cfg_num_rows(cfg_num_rows),
    .cfg_stride(cfg_stride), .cfg_reuse_flt(cfg_reuse_flt),
    .flt_valid(flt_valid), .flt_data(flt_data), .flt_ready(flt_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  longint oq_val[$];
  int     oq_cyc[$];
  int     err_cnt = 0;
  int     fr_cnt  = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      oq_val.push_back(longint'(out_data));
      oq_cyc.push_back(cyc);
    end
    if (done && cfg_err) err_cnt++;
    if (flt_ready) fr_cnt++;
  end

  typedef struct {
    int                         w;
    int                         h;
    bit                         stride;
    bit                         reuse;
    bit                         gap;
    bit                         ramp;
    logic [0:8][DATA_W-1:0]     flt;
    logic [DATA_W-1:0]          pconst;
    int                         n_out;
    logic [0:8][ACC_W-1:0]      exp_val;
    logic [0:8][7:0]            exp_idx;
  } vec_t;

  vec_t vecs[8];
  int   hs_cyc[64];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(int w, int h, bit s, bit reuse, bit gap, bit ramp,
                              logic [0:8][DATA_W-1:0] f, logic [DATA_W-1:0] pc,
                              int n_out, logic [0:8][ACC_W-1:0] ev, logic [0:8][7:0] ei);
    vec_t v;
    v.w = w; v.h = h; v.stride = s; v.reuse = reuse; v.gap = gap; v.ramp = ramp;
    v.flt = f; v.pconst = pc; v.n_out = n_out; v.exp_val = ev; v.exp_idx = ei;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_flt(input logic [0:8][DATA_W-1:0] f, input string tag);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < 9 && guard < 50) begin
      flt_valid = 1'b1;
      flt_data  = f[k];
      acc = flt_ready;
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    flt_valid = 1'b0;
    chk({tag, "_flt_load"}, k, 9);
  endtask

  task automatic do_start(input int w, input int h, input bit s, input bit reuse);
    @(negedge clk);
    start = 1'b1;
    cfg_row_length = ROW_W'(w);
    cfg_num_rows = ROW_W'(h);
    cfg_stride = s;
    cfg_reuse_flt = reuse;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds up to n_pix pixels; records the handshake cycle of each
  task automatic feed(input vec_t v, input int n_pix, output int fed);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < n_pix && guard < 2000) begin
      pix_valid = v.gap ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = v.ramp ? DATA_W'(idx) : v.pconst;
      acc = pix_valid && pix_ready;
      if (acc) hs_cyc[idx] = cyc;
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    fed = idx;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    int    n, fed, base_q, base_fr, base_err, nq, guard;
    bit    seen;
    string tag;
    v = vecs[i];
    n = v.w * v.h;
    tag = $sformatf("v%0d", i);
    base_q = oq_val.size();
    base_fr = fr_cnt;
    base_err = err_cnt;
    do_start(v.w, v.h, v.stride, v.reuse);
    if (!v.reuse) load_flt(v.flt, tag);
    feed(v, n, fed);
    chk({tag, "_pix_count"}, fed, n);
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 20) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_done_lat"}, cyc, hs_cyc[n-1] + 3);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
    nq = oq_val.size() - base_q;
    chk({tag, "_out_count"}, nq, v.n_out);
    for (int j = 0; j < v.n_out && j < nq; j++) begin
      chk($sformatf("%s_val%0d", tag, j), oq_val[base_q+j], longint'($signed(v.exp_val[j])));
      chk($sformatf("%s_lat%0d", tag, j), oq_cyc[base_q+j], hs_cyc[v.exp_idx[j]] + 2);
    end
    chk({tag, "_cfg_err"}, err_cnt - base_err, 0);
    if (v.reuse) chk({tag, "_flt_ready_reuse"}, fr_cnt - base_fr, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, longint'(out_data), 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_flt_ready"}, flt_ready, 0);
    chk({tag, "_pix_ready"}, pix_ready, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [0:8][DATA_W-1:0] f_id, f_one, f_neg;
    logic [0:8][ACC_W-1:0]  e_id5, e_s2;
    logic [0:8][7:0]        i_id5, i_s2;
    int fed, base_q, base_fr;

    f_id  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    f_one = {9{16'd1}};
    f_neg = {9{16'h8000}};
    e_id5 = {36'd6, 36'd7, 36'd8, 36'd11, 36'd12, 36'd13, 36'd16, 36'd17, 36'd18};
    i_id5 = {8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24};
    e_s2  = {36'd8, 36'd10, 36'd12, 36'd22, 36'd24, 36'd26, 36'd36, 36'd38, 36'd40};
    i_s2  = {8'd16, 8'd18, 8'd20, 8'd30, 8'd32, 8'd34, 8'd44, 8'd46, 8'd48};

    //          w  h  s  reuse gap ramp flt    pconst        n  exp values / completing pixel
    vecs[0] = mk(5, 5, 0, 0, 0, 1, f_id,  16'd0,     9, e_id5, i_id5);
    vecs[1] = mk(4, 4, 0, 0, 0, 0, f_one, 16'd1,     4, {{4{36'd9}}, {5{36'd0}}},
                 {8'd10, 8'd11, 8'd14, 8'd15, {5{8'd0}}});
    vecs[2] = mk(7, 7, 1, 0, 0, 1, f_id,  16'd0,     9, e_s2, i_s2);
    vecs[3] = mk(3, 3, 0, 0, 0, 0, f_neg, 16'h8000,  1, {36'sd9663676416, {8{36'd0}}},
                 {8'd8, {8{8'd0}}});
    vecs[4] = mk(3, 3, 0, 0, 0, 0, f_neg, 16'sd32767, 1, {-36'sd9663381504, {8{36'd0}}},
                 {8'd8, {8{8'd0}}});
    vecs[5] = mk(5, 5, 0, 0, 1, 1, f_id,  16'd0,     9, e_id5, i_id5);
    vecs[6] = mk(5, 5, 0, 1, 1, 1, f_id,  16'd0,     9, e_id5, i_id5);
    // reuse right after reset: coefficients were cleared, so every window is 0
    vecs[7] = mk(5, 5, 0, 1, 0, 1, f_id,  16'd0,     9, '0, i_id5);

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset just after the first window-completing pixel is accepted
    do_start(5, 5, 0, 0);
    load_flt(f_id, "rst_seq");
    feed(vecs[0], 13, fed);
    chk("rst_seq_fed", fed, 13);
    base_q = oq_val.size();
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_mid");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_no_stray", oq_val.size() - base_q, 0);
    run_vec(7);
    run_vec(0);

    // Illegal configurations: W=2, then H=2
    for (int t = 0; t < 2; t++) begin
      base_q = oq_val.size();
      base_fr = fr_cnt;
      do_start(t == 0 ? 2 : 5, t == 0 ? 5 : 2, 0, 0);
      chk($sformatf("ill%0d_done", t), done, 1);
      chk($sformatf("ill%0d_cfg_err", t), cfg_err, 1);
      chk($sformatf("ill%0d_pix_ready", t), pix_ready, 0);
      @(negedge clk);
      chk($sformatf("ill%0d_done_pulse", t), done, 0);
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("ill%0d_no_out", t), oq_val.size() - base_q, 0);
      chk($sformatf("ill%0d_no_flt_ready", t), fr_cnt - base_fr, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
